// File: rtl/reg_file_param.sv
// Parametrised register file with one write port and two registered read ports.
// It has an optional hardwired-zero entry 0, optional write-to-read forwarding and a sequential bulk-clear engine.
module reg_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  input  logic                  CLR,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2,
  output logic                  RD_VALID,
  output logic                  BUSY
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   r_data_r1;
  logic [DATA_WIDTH-1:0]   r_data_r2;
  logic                    r_rd_valid;
  logic                    w_busy;
  logic                    w_wr_en;
  logic                    w_rd_en;
  logic [DATA_WIDTH-1:0]   w_rd1;
  logic [DATA_WIDTH-1:0]   w_rd2;

  assign w_busy  = (r_state == CLEAR);
  assign w_wr_en = WRITE && !w_busy && !((ZERO_REG != 0) && (ADDR_W == '0));
  assign w_rd_en = READ && !w_busy;

  // Zero entry wins, then same-edge forwarding, then stored contents.
  always_comb begin
    w_rd1 = r_mem[ADDR_R1];
    w_rd2 = r_mem[ADDR_R2];
    if ((BYPASS != 0) && w_wr_en && (ADDR_R1 == ADDR_W)) w_rd1 = DATA_W;
    if ((BYPASS != 0) && w_wr_en && (ADDR_R2 == ADDR_W)) w_rd2 = DATA_W;
    if ((ZERO_REG != 0) && (ADDR_R1 == '0)) w_rd1 = '0;
    if ((ZERO_REG != 0) && (ADDR_R2 == '0)) w_rd2 = '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_busy) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_en) begin
      r_mem[ADDR_W] <= DATA_W;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_data_r1  <= '0;
      r_data_r2  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_en;
      if (w_rd_en) begin
        r_data_r1 <= w_rd1;
        r_data_r2 <= w_rd2;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (CLR) w_next_state = CLEAR;
      CLEAR:   if (r_cnt == '1) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The counter wraps to zero on the last clear cycle, so no extra state is needed.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_busy) r_cnt <= r_cnt + 1'b1;
      else if (CLR) r_cnt <= '0;
    end
  end

  assign DATA_R1  = r_data_r1;
  assign DATA_R2  = r_data_r2;
  assign RD_VALID = r_rd_valid;
  assign BUSY     = w_busy;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: instance A uses the default parameters, and instance B has no zero register and no bypass.
// Both instances share the same stimulus.
module tb_reg_file_param;

  logic        CLK = 1'b0;
  logic        RST;
  logic        READ, WRITE, CLR;
  logic [4:0]  ADDR_R1, ADDR_R2, ADDR_W;
  logic [31:0] DATA_W;
  logic [31:0] a_r1, a_r2, b_r1, b_r2;
  logic        a_valid, a_busy, b_valid, b_busy;
  int          checks = 0;
  int          failures = 0;
  int          n;

  always #5 CLK = ~CLK;

  reg_file_param dutA (
    .CLK(CLK), .RST(RST), .READ(READ), .WRITE(WRITE),
    .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .CLR(CLR), .DATA_R1(a_r1), .DATA_R2(a_r2), .RD_VALID(a_valid), .BUSY(a_busy)
  );

  reg_file_param #(.ZERO_REG(0), .BYPASS(0)) dutB (
    .CLK(CLK), .RST(RST), .READ(READ), .WRITE(WRITE),
    .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .CLR(CLR), .DATA_R1(b_r1), .DATA_R2(b_r2), .RD_VALID(b_valid), .BUSY(b_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [4:0] ar1,
                               input logic [4:0] ar2, input logic [4:0] aw,
                               input logic [31:0] dw, input logic clr);
    READ = rd; WRITE = wr; ADDR_R1 = ar1; ADDR_R2 = ar2; ADDR_W = aw; DATA_W = dw; CLR = clr;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0;
    READ = 0; WRITE = 0; CLR = 0; ADDR_R1 = 0; ADDR_R2 = 0; ADDR_W = 0; DATA_W = 0;
    #3;
    checkOutput("reset_r1", a_r1, 32'h0);
    checkOutput("reset_valid", {31'b0, a_valid}, 32'h0);
    checkOutput("reset_busy", {31'b0, a_busy}, 32'h0);
    #10 RST = 1'b1;

    // Basic write, then read with the zero register on port 2.
    applyStimulus(0, 1, 0, 0, 5, 32'hDEADBEEF, 0);
    applyStimulus(1, 0, 5, 0, 0, 0, 0);
    checkOutput("rd5_r1", a_r1, 32'hDEADBEEF);
    checkOutput("rd5_r2", a_r2, 32'h0);
    checkOutput("rd5_valid", {31'b0, a_valid}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("idle_valid", {31'b0, a_valid}, 32'h0);
    checkOutput("idle_hold", a_r1, 32'hDEADBEEF);

    // Zero register behaviour versus an ordinary entry 0.
    applyStimulus(0, 1, 0, 0, 0, 32'h12345678, 0);
    applyStimulus(1, 0, 0, 5, 0, 0, 0);
    checkOutput("zero_A_r1", a_r1, 32'h0);
    checkOutput("zero_B_r1", b_r1, 32'h12345678);
    checkOutput("zero_B_r2", b_r2, 32'hDEADBEEF);

    // Same-edge write and read.
    applyStimulus(0, 1, 0, 0, 7, 32'h1, 0);
    applyStimulus(1, 1, 7, 8, 7, 32'hA5A5A5A5, 0);
    checkOutput("byp_A_r1", a_r1, 32'hA5A5A5A5);
    checkOutput("byp_B_r1", b_r1, 32'h1);
    checkOutput("byp_A_r2", a_r2, 32'h0);
    applyStimulus(1, 1, 5, 8, 8, 32'h0000BEEF, 0);
    checkOutput("byp_A_r2_new", a_r2, 32'h0000BEEF);
    checkOutput("byp_B_r2_old", b_r2, 32'h0);
    applyStimulus(1, 1, 0, 7, 0, 32'h99, 0);
    checkOutput("byp_zero_A_r1", a_r1, 32'h0);
    checkOutput("byp_zero_B_r1", b_r1, 32'h12345678);
    checkOutput("rd7_A", a_r2, 32'hA5A5A5A5);
    checkOutput("rd7_B", b_r2, 32'hA5A5A5A5);

    // Fill every entry, then bulk clear.
    for (int i = 0; i < 32; i++) applyStimulus(0, 1, 0, 0, i[4:0], 32'h100 + i, 0);
    applyStimulus(1, 0, 31, 3, 0, 0, 0);
    checkOutput("fill_A_r1", a_r1, 32'h11F);
    checkOutput("fill_A_r2", a_r2, 32'h103);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("clr_busy_start", {31'b0, a_busy}, 32'h1);
    n = 0;
    while (a_busy && n < 100) begin
      n++;
      if (n >= 2 && n <= 5) applyStimulus(1, 1, 3, 3, 3, 32'hBAD, n == 3);
      else applyStimulus(0, 0, 0, 0, 0, 0, 0);
      if (n == 3) checkOutput("busy_valid", {31'b0, a_valid}, 32'h0);
    end
    checkOutput("clr_cycles", n, 32);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1, 0, i[4:0], 5'(31 - i), 0, 0, 0);
      checkOutput($sformatf("clr_A_r1_%0d", i), a_r1, 32'h0);
      checkOutput($sformatf("clr_B_r2_%0d", i), b_r2, 32'h0);
    end

    // Reset in the middle of a clear.
    applyStimulus(0, 1, 0, 0, 3, 32'h33, 0);
    applyStimulus(0, 1, 0, 0, 20, 32'h20, 0);
    applyStimulus(1, 0, 3, 20, 0, 0, 0);
    checkOutput("pre_r1", a_r1, 32'h33);
    checkOutput("pre_r2", a_r2, 32'h20);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("mid_busy", {31'b0, a_busy}, 32'h1);
    checkOutput("mid_hold", a_r1, 32'h33);
    #2 RST = 1'b0;
    #1;
    checkOutput("rst_busy", {31'b0, a_busy}, 32'h0);
    checkOutput("rst_r1", a_r1, 32'h0);
    checkOutput("rst_r2", a_r2, 32'h0);
    #1 RST = 1'b1;
    applyStimulus(1, 0, 20, 3, 0, 0, 0);
    checkOutput("rst_mem20", a_r1, 32'h0);
    checkOutput("rst_mem3", b_r2, 32'h0);
    checkOutput("rst_read_valid", {31'b0, a_valid}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    n = 0;
    while (a_busy && n < 100) begin
      n++;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
    end
    checkOutput("reclr_cycles", n, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
